// File: rtl/dice_pkg.sv
// dice_pkg: die codes, accept window and FSM encoding shared by
// the roll scheduler and its reducer.
package dice_pkg;

  localparam logic [3:0] D4       = 4'd0;
  localparam logic [3:0] D6       = 4'd1;
  localparam logic [3:0] D8       = 4'd2;
  localparam logic [3:0] D10      = 4'd3;
  localparam logic [3:0] D12      = 4'd4;
  localparam logic [3:0] D20      = 4'd5;
  localparam logic [3:0] DIE_NONE = 4'hF;

  // 120 is the lcm of every face count, so the window is bias-free
  localparam logic [6:0] ACCEPT_MIN = 7'd1;
  localparam logic [6:0] ACCEPT_MAX = 7'd120;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_CALC   = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;

  function automatic logic [4:0] sides_of(input logic [3:0] code);
    unique case (code)
      D4:       sides_of = 5'd4;
      D6:       sides_of = 5'd6;
      D8:       sides_of = 5'd8;
      D10:      sides_of = 5'd10;
      D12:      sides_of = 5'd12;
      D20:      sides_of = 5'd20;
      DIE_NONE: sides_of = 5'd0;
      default:  sides_of = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/roll_scheduler_if.sv
// roll_scheduler_if: request, TRNG and response channels of the
// roll scheduler; slave = scheduler, master = its environment.
interface roll_scheduler_if #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);

  logic [NUM_REQ-1:0]   i_req_valid;
  logic [4*NUM_REQ-1:0] i_req_die;
  logic [NUM_REQ-1:0]   o_req_ready;
  logic                 o_stop;
  logic                 i_valid;
  logic [6:0]           i_randomData;
  logic                 o_rsp_valid;
  logic [IDW-1:0]       o_rsp_id;
  logic [4:0]           o_rsp_roll;
  logic                 o_rsp_err;
  logic                 i_rsp_ready;

  modport slave (
    input  i_req_valid, i_req_die, i_valid,
    input  i_randomData, i_rsp_ready,
    output o_req_ready, o_stop, o_rsp_valid,
    output o_rsp_id, o_rsp_roll, o_rsp_err
  );

  modport master (
    output i_req_valid, i_req_die, i_valid,
    output i_randomData, i_rsp_ready,
    input  o_req_ready, o_stop, o_rsp_valid,
    input  o_rsp_id, o_rsp_roll, o_rsp_err
  );

endinterface

// File: rtl/die_reduce.sv
// die_reduce: maps an accepted 7-bit sample onto a 1-based face
// of the selected die; roll is 0 for an unknown die code.
module die_reduce
  import dice_pkg::*;
(
  input  logic [6:0] sample_i,
  input  logic [3:0] code_i,
  output logic [4:0] roll_o,
  output logic       code_ok_o
);

  logic [4:0] sides;
  logic [6:0] rem;
  logic       unused_hi;

  assign sides     = sides_of(code_i);
  assign code_ok_o = (sides != 5'd0);

  always_comb begin
    rem = '0;
    if (code_ok_o) rem = sample_i % {2'b00, sides};
  end

  // remainder is below 20, so the top bits are always zero
  assign unused_hi = ^rem[6:5];
  assign roll_o    = code_ok_o ? rem[4:0] + 5'd1 : 5'd0;

endmodule

// File: rtl/roll_scheduler.sv
// roll_scheduler: TRNG sequencer and round-robin die-roll arbiter.
// Rejection-samples 7-bit draws and returns a tagged die face.
module roll_scheduler
  import dice_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int SETTLE_CYC = 4,
  parameter int MAX_TRIES  = 16
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  roll_scheduler_if.slave bus,
  output logic            o_busy
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW  = $clog2(MAX_TRIES + 1);
  localparam int SW  = $clog2(SETTLE_CYC + 1);

  logic [2:0]     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [3:0]     die_q, die_d;
  logic [6:0]     smp_q, smp_d;
  logic [TW-1:0]  tries_q, tries_d;
  logic [SW-1:0]  settle_q, settle_d;
  logic [4:0]     roll_q, roll_d;
  logic           err_q, err_d;
  logic           stop_q, vld_q;

  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;
  logic [3:0]     gnt_die;
  logic [3:0]     red_code;
  logic [4:0]     red_roll;
  logic           red_ok;
  int             k;

  // scan from ptr downward so the closest requester wins last
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    k       = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = (int'(ptr_q) + i) % NUM_REQ;
      if (bus.i_req_valid[k]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'(k);
      end
    end
  end

  assign gnt_die = bus.i_req_die[4*int'(gnt_idx) +: 4];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      bus.o_req_ready[i] = (state_q == S_IDLE) && gnt_any
                        && (gnt_idx == IDW'(i));
  end

  // reducer checks the incoming code at grant, the held one later
  assign red_code = (state_q == S_IDLE) ? gnt_die : die_q;

  die_reduce u_reduce (
    .sample_i  (smp_q),
    .code_i    (red_code),
    .roll_o    (red_roll),
    .code_ok_o (red_ok)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    die_d    = die_q;
    smp_d    = smp_q;
    tries_d  = tries_q;
    settle_d = settle_q;
    roll_d   = roll_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          ptr_d  = IDW'((int'(gnt_idx) + 1) % NUM_REQ);
          id_d   = gnt_idx;
          die_d  = gnt_die;
          roll_d = '0;
          err_d  = !red_ok;
          state_d = red_ok ? S_RUN : S_RESP;
        end
      end
      S_RUN: begin
        if (bus.i_valid) begin
          smp_d   = bus.i_randomData;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (smp_q >= ACCEPT_MIN && smp_q <= ACCEPT_MAX) begin
          state_d = S_CALC;
        end else begin
          tries_d = tries_q + 1'b1;
          if (tries_q == TW'(MAX_TRIES - 1)) begin
            err_d   = 1'b1;
            roll_d  = '0;
            state_d = S_RESP;
          end else begin
            settle_d = '0;
            state_d  = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (settle_q == SW'(SETTLE_CYC - 1)) state_d = S_RUN;
        else settle_d = settle_q + 1'b1;
      end
      S_CALC: begin
        roll_d  = red_roll;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.i_rsp_ready) begin
          tries_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      die_q    <= DIE_NONE;
      smp_q    <= '0;
      tries_q  <= '0;
      settle_q <= '0;
      roll_q   <= '0;
      err_q    <= 1'b0;
      stop_q   <= 1'b1;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      die_q    <= die_d;
      smp_q    <= smp_d;
      tries_q  <= tries_d;
      settle_q <= settle_d;
      roll_q   <= roll_d;
      err_q    <= err_d;
      stop_q   <= (state_d != S_RUN);
      vld_q    <= (state_d == S_RESP);
    end
  end

  assign bus.o_stop      = stop_q;
  assign bus.o_rsp_valid = vld_q;
  assign bus.o_rsp_id    = id_q;
  assign bus.o_rsp_roll  = roll_q;
  assign bus.o_rsp_err   = err_q;
  assign o_busy          = (state_q != S_IDLE);

endmodule
